regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Sequences the register file's single write port (A3/WD3/WE3) between two writeback sources: the ALU result path and the memory load path.
- Each source uses a valid/ready handshake. An arbiter picks one per cycle and registers the winner onto the write port.
- Also keeps a per-register busy scoreboard. Issue logic reserves destinations; writeback clears them. Decode uses busy to stall on pending writes.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width.
- NREG, 32, number of registers tracked by the scoreboard (2**ADDR_W).
- PRIO_MEM, 0, arbitration mode: 0 = round-robin, 1 = fixed priority to the memory source.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous reset, active-high.
- alu_valid  input  1  ALU writeback request.
- alu_ready  output  1  ALU request accepted this cycle.
- alu_addr  input  ADDR_W  ALU destination register.
- alu_data  input  DATA_W  ALU result.
- mem_valid  input  1  load writeback request.
- mem_ready  output  1  load request accepted this cycle.
- mem_addr  input  ADDR_W  load destination register.
- mem_data  input  DATA_W  load data.
- rsv_valid  input  1  issue reserves a destination.
- rsv_addr  input  ADDR_W  register being reserved.
- busy  output  NREG  scoreboard; bit i = write to register i pending.
- WE3  output  1  register file write enable.
- A3  output  ADDR_W  register file write address.
- WD3  output  DATA_W  register file write data.

Behaviour:
- Reset (async, rst=1):
  - WE3=0, A3=0, WD3=0, busy=0.
  - alu_ready=mem_ready=0 while rst is high.
  - Round-robin pointer last_grant=MEM, so the ALU wins the first tie.
  - Asserting rst mid-transfer drops WE3 immediately. A pending accepted write is discarded, not replayed.
- Handshake:
  - A transfer occurs on a posedge where valid && ready.
  - ready is combinational from both valids, PRIO_MEM and last_grant. It must never depend on WE3 or on future state.
  - At most one ready is high per cycle.
  - Sources hold valid/addr/data stable until accepted. The block does not check this.
- Arbitration:
  - Only one valid: that source is granted.
  - Both valid, PRIO_MEM=1: MEM always granted.
  - Both valid, PRIO_MEM=0: grant the source not equal to last_grant.
  - last_grant updates only on a grant.
  - Neither valid: no grant; pointer and outputs hold.
- Latency:
  - A grant at edge N drives WE3=1 with the granted A3/WD3 for cycle N..N+1. The register file commits at edge N+1.
  - No grant at edge N: WE3=0 next cycle; A3/WD3 hold their last values.
  - Back-to-back grants give continuous WE3=1 with new A3/WD3 each cycle. Throughput is 1 write/cycle.
- Scoreboard:
  - rsv_valid at an edge sets busy[rsv_addr].
  - A grant at an edge clears busy[granted addr] at that same edge, i.e. busy clears when the write is committed to A3/WD3, one cycle before the register file commit.
  - Decode must also bypass or stall on WE3 && A3 match; this block does not forward.
  - Set and clear of the same address on the same edge: set wins, since a new reservation supersedes.
  - Clear of a non-busy register: no effect, no error.
- Same-address conflicts:
  - Both sources target the same address: both writes are performed in grant order, and the later grant's data is final.
  - Such an ordering hazard is issue logic's responsibility.
- Width rules: addresses are used as-is with no masking. Register 0 is a normal writable register.

Test Plan:
- Reset released, alu_valid=1 only, alu_addr=9, alu_data=32'h00000020 -> alu_ready=1 in that cycle; next cycle WE3=1, A3=9, WD3=32'h20; following cycle WE3=0, A3 still 9.
- PRIO_MEM=0, both valid continuously, ALU addr=3 data=AAAA_0001, MEM addr=4 data=BBBB_0002 -> grants alternate ALU, MEM, ALU, MEM; WE3 stays 1; A3 sequence 3,4,3,4.
- PRIO_MEM=1, both valid for 3 cycles -> mem_ready=1 and alu_ready=0 every cycle; A3 equals mem_addr each cycle.
- rsv_valid with rsv_addr=7, then ALU writes addr 7 two cycles later -> busy[7]=1 after the reserve edge, 0 after the grant edge; also rsv 7 and grant 7 on the same edge -> busy[7] stays 1.
- Both sources target addr 5, ALU data 1 then MEM data 2 (round-robin) -> two consecutive writes to 5; final WD3=2.
- rst asserted asynchronously mid-cycle while WE3=1 and busy=32'h0000_0180 -> WE3, A3, WD3 and busy go to 0 without waiting for a clock edge; readies low during rst; after release, the first tie goes to the ALU.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU/load writebacks onto the register-file write port; a grant appears on WE3/A3/WD3 one cycle later.
// Readies are combinational grants, at most one per cycle; a per-register busy scoreboard tracks pending writes.
module regfile_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREG     = 32,
  parameter int PRIO_MEM = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [NREG-1:0]   busy,
  output logic              WE3,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3
);

  // last_mem=1 means the memory source won the most recent grant
  logic              last_mem;
  logic              grant_alu;
  logic              grant_mem;
  logic              grant;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic [NREG-1:0]   busy_next;

  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (!rst) begin
      if (alu_valid && mem_valid) begin
        if (PRIO_MEM != 0) begin
          grant_mem = 1'b1;
        end else begin
          grant_alu = last_mem;
          grant_mem = !last_mem;
        end
      end else begin
        grant_alu = alu_valid;
        grant_mem = mem_valid;
      end
    end
  end

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;
  assign grant     = grant_alu || grant_mem;
  assign win_addr  = grant_mem ? mem_addr : alu_addr;
  assign win_data  = grant_mem ? mem_data : alu_data;

  // A new reservation on the same edge supersedes the clear from a grant
  always_comb begin
    busy_next = busy;
    if (grant) begin
      busy_next[win_addr] = 1'b0;
    end
    if (rsv_valid) begin
      busy_next[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_mem <= 1'b1;
      WE3      <= 1'b0;
      A3       <= '0;
      WD3      <= '0;
      busy     <= '0;
    end else begin
      WE3  <= grant;
      busy <= busy_next;
      if (grant) begin
        last_mem <= grant_mem;
        A3       <= win_addr;
        WD3      <= win_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench: expected writes are queued at grant time and checked when WE3 shows them.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0, mem_valid = 1'b0, rsv_valid = 1'b0;
  logic [4:0]  alu_addr = '0, mem_addr = '0, rsv_addr = '0;
  logic [31:0] alu_data = '0, mem_data = '0;
  logic        alu_ready, mem_ready, WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [31:0] busy;

  // second instance, fixed priority to memory
  logic        p_alu_valid = 1'b0, p_mem_valid = 1'b0;
  logic [4:0]  p_alu_addr = '0, p_mem_addr = '0;
  logic [31:0] p_alu_data = '0, p_mem_data = '0;
  logic        p_alu_ready, p_mem_ready, p_WE3;
  logic [4:0]  p_A3;
  logic [31:0] p_WD3;
  logic [31:0] p_busy;

  int errors = 0;
  int checks = 0;
  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .NREG(32), .PRIO_MEM(0)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .busy(busy),
    .WE3(WE3), .A3(A3), .WD3(WD3)
  );

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .NREG(32), .PRIO_MEM(1)) dut_prio (
    .clk(clk), .rst(rst),
    .alu_valid(p_alu_valid), .alu_ready(p_alu_ready), .alu_addr(p_alu_addr), .alu_data(p_alu_data),
    .mem_valid(p_mem_valid), .mem_ready(p_mem_ready), .mem_addr(p_mem_addr), .mem_data(p_mem_data),
    .rsv_valid(1'b0), .rsv_addr(5'd0), .busy(p_busy),
    .WE3(p_WE3), .A3(p_A3), .WD3(p_WD3)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle with WE3 high must match the oldest queued grant
  always @(negedge clk) begin
    if (!rst && WE3) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got A3=%0d WD3=%0h expected no write", A3, WD3);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("wb_write", {27'd0, A3, WD3}, {27'd0, e});
      end
    end
  end

  initial begin
    // reset state, readies held low while rst is high
    alu_valid = 1'b1;
    @(negedge clk);
    chk("rst_we3", WE3, 0);
    chk("rst_a3_wd3", {A3, WD3}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_ready", alu_ready, 0);
    alu_valid = 1'b0;
    tick();
    rst = 1'b0;

    // single ALU write
    alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h20;
    @(negedge clk);
    chk("t1_readies", {alu_ready, mem_ready}, 2'b10);
    exp_q.push_back({5'd9, 32'h20});
    tick();
    alu_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("t1_idle_we3_a3", {WE3, A3}, {1'b0, 5'd9});

    // memory-only write leaves last_grant=MEM
    tick();
    mem_valid = 1'b1; mem_addr = 5'd1; mem_data = 32'h11;
    @(negedge clk);
    chk("mem_only_ready", {alu_ready, mem_ready}, 2'b01);
    exp_q.push_back({5'd1, 32'h11});
    tick();
    mem_valid = 1'b0;

    // round-robin alternation with both sources valid
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'hAAAA_0001;
    mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'hBBBB_0002;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_readies", {alu_ready, mem_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (i % 2 == 0) exp_q.push_back({5'd3, 32'hAAAA_0001});
      else            exp_q.push_back({5'd4, 32'hBBBB_0002});
      if (i > 0) chk("rr_we3_cont", WE3, 1);
      tick();
    end
    alu_valid = 1'b0; mem_valid = 1'b0;

    // fixed priority instance
    p_alu_valid = 1'b1; p_alu_addr = 5'd10; p_alu_data = 32'hA;
    p_mem_valid = 1'b1; p_mem_addr = 5'd11; p_mem_data = 32'hB;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("prio_readies", {p_alu_ready, p_mem_ready}, 2'b01);
      if (i > 0) chk("prio_a3", {p_WE3, p_A3}, {1'b1, 5'd11});
      tick();
    end
    p_alu_valid = 1'b0; p_mem_valid = 1'b0;
    @(negedge clk);
    chk("prio_a3_last", {p_WE3, p_A3, p_WD3}, {1'b1, 5'd11, 32'hB});
    tick();

    // scoreboard set, clear, and same-edge set-wins
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    tick();
    rsv_valid = 1'b0;
    chk("busy7_set", busy, 32'h80);
    tick();
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h77;
    @(negedge clk);
    exp_q.push_back({5'd7, 32'h77});
    tick();
    alu_valid = 1'b0;
    chk("busy7_clr", busy, 32'h0);
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h78;
    @(negedge clk);
    exp_q.push_back({5'd7, 32'h78});
    tick();
    alu_valid = 1'b0;
    chk("busy7_setwins", busy, 32'h80);
    rsv_addr = 5'd8;
    tick();
    rsv_valid = 1'b0;
    chk("busy_180", busy, 32'h180);

    // same-address writes from both sources in grant order
    mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 32'h22;
    @(negedge clk);
    exp_q.push_back({5'd2, 32'h22});
    tick();
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h1;
    mem_valid = 1'b1; mem_addr = 5'd5; mem_data = 32'h2;
    @(negedge clk);
    chk("same_first_alu", {alu_ready, mem_ready}, 2'b10);
    exp_q.push_back({5'd5, 32'h1});
    tick();
    alu_valid = 1'b0;
    @(negedge clk);
    chk("same_second_mem", {alu_ready, mem_ready}, 2'b01);
    exp_q.push_back({5'd5, 32'h2});
    tick();
    mem_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("same_final", {WE3, A3, WD3}, {1'b0, 5'd5, 32'h2});

    // asynchronous reset mid-write discards the pending write
    tick();
    alu_valid = 1'b1; alu_addr = 5'd12; alu_data = 32'hC;
    @(negedge clk);
    tick();
    alu_valid = 1'b0;
    chk("pre_rst_state", {WE3, busy}, {1'b1, 32'h180});
    rst = 1'b1;
    #1;
    chk("async_rst_clear", {WE3, A3, WD3, busy}, 0);
    alu_valid = 1'b1; mem_valid = 1'b1;
    alu_addr = 5'd13; alu_data = 32'hD; mem_addr = 5'd14; mem_data = 32'hE;
    #1;
    chk("rst_readies_low", {alu_ready, mem_ready}, 2'b00);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_tie_alu", {alu_ready, mem_ready}, 2'b10);
    exp_q.push_back({5'd13, 32'hD});
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    tick();
    tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
